// File: rtl/case_9_prod_accum_pkg.sv
// case_9_prod_accum_pkg: shared state encoding, accumulator limits and saturating add helper
package case_9_prod_accum_pkg;
  localparam int DIN_W = 10;
  localparam int ACC_W = 16;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, OUTPUT = 2'd2} state_t;
  function automatic logic [ACC_W:0] satadd(input logic signed [ACC_W-1:0] a, input logic signed [DIN_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = a + b;
    return (s[ACC_W] != s[ACC_W-1]) ? {1'b1, s[ACC_W] ? ACC_MIN : ACC_MAX} : {1'b0, s[ACC_W-1:0]};
  endfunction
endpackage

// File: rtl/case_9_satadd.sv
// case_9_satadd: combinational saturating add of a sign-extended input onto an accumulator
module case_9_satadd #(
  parameter int DIN_WIDTH = 10,
  parameter int ACC_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  input  logic [DIN_WIDTH-1:0] i_din,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_clamp
);
  logic [ACC_WIDTH:0] w_sum;
  assign w_sum = {i_acc[ACC_WIDTH-1], i_acc} + {{(ACC_WIDTH+1-DIN_WIDTH){i_din[DIN_WIDTH-1]}}, i_din};
  // the two top bits of the widened sum disagree exactly when the result left the signed range
  assign o_clamp = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
  assign o_sum = !o_clamp ? w_sum[ACC_WIDTH-1:0] :
                 w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
endmodule

// File: rtl/case_9_prod_accum.sv
// case_9_prod_accum: accumulates a programmed number of signed products with saturation,
// result presented on a valid/ready handshake under ap_* block control
module case_9_prod_accum
  import case_9_prod_accum_pkg::*;
#(
  parameter int DIN_WIDTH = 10,
  parameter int ACC_WIDTH = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 ap_ready,
  output logic                 ap_idle,
  output logic                 ap_done,
  input  logic [DIN_WIDTH-1:0] prod_din,
  input  logic                 prod_vld,
  output logic                 prod_rdy,
  output logic [ACC_WIDTH-1:0] res_dout,
  output logic                 res_sat,
  output logic                 res_vld,
  input  logic                 res_rdy
);
  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic                 r_sat;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_clamp;
  logic                 w_xfer;
  case_9_satadd #(.DIN_WIDTH(DIN_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_satadd (
    .i_acc  (r_acc),
    .i_din  (prod_din),
    .o_sum  (w_sum),
    .o_clamp(w_clamp)
  );
  assign ap_idle  = r_state == IDLE;
  assign ap_ready = ap_idle & ap_start;
  assign prod_rdy = r_state == ACCUM;
  assign res_vld  = r_state == OUTPUT;
  assign ap_done  = res_vld & res_rdy;
  assign res_dout = r_acc;
  assign res_sat  = r_sat;
  assign w_xfer   = prod_vld & prod_rdy;
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (ap_start) begin
          r_cnt   <= len;
          r_acc   <= '0;
          r_sat   <= 1'b0;
          r_state <= (len == '0) ? OUTPUT : ACCUM;
        end
        ACCUM: if (w_xfer) begin
          r_acc   <= w_sum;
          r_sat   <= r_sat | w_clamp;
          r_cnt   <= r_cnt - LEN_WIDTH'(1);
          r_state <= (r_cnt == LEN_WIDTH'(1)) ? OUTPUT : ACCUM;
        end
        OUTPUT: if (res_rdy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
